// File: rtl/rsp_s1_prep_pkg.sv
// Shared types and defaults for the S1 prep differentiator slice.
// PIPE_LAT follows the diff stage's x0->y0 valid delay so controller and datapath agree.
`ifndef DELAY_DIFF_X0_VALID
`define DELAY_DIFF_X0_VALID 4
`endif

package rsp_s1_prep_pkg;

    localparam int DIFF_DATA_NUM = 1024;
    localparam int DIFF_PIPE_LAT = `DELAY_DIFF_X0_VALID;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } diff_ctrl_state_t;

endpackage

// File: rtl/delay.sv
// Fixed-depth register delay line, cleared by reset.
module delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/rsp_s1_prep_diff_ctrl.sv
// Frame sequencer: reads DATA_NUM-beat frames from a ping-pong RAM into the diff stage,
// holding the sel/switch mode for a whole frame and changing it only after the pipe drains.
module rsp_s1_prep_diff_ctrl
    import rsp_s1_prep_pkg::*;
#(
    parameter int DATA_NUM = DIFF_DATA_NUM,
    parameter int PIPE_LAT = DIFF_PIPE_LAT,
    parameter int FRAME_W  = 16,
    parameter int ADDR_W   = $clog2(DATA_NUM) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame_num,
    input  logic               i_cfg_sel_16_32,
    input  logic               i_cfg_switch,
    input  logic               i_ds_ready,
    output logic               o_rd_en,
    output logic [ADDR_W-1:0]  o_rd_addr,
    output logic               o_sel_16_32,
    output logic               o_switch,
    output logic               o_x0_valid,
    output logic               o_x0_last,
    output logic               o_busy,
    output logic               o_done,
    output logic [FRAME_W-1:0] o_frame_cnt
);

    localparam int BEAT_W  = ADDR_W - 1;
    localparam int DRAIN_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(DATA_NUM - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT);

    diff_ctrl_state_t state_q, state_d;

    logic               bank_q, bank_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [FRAME_W-1:0] frames_left_q, frames_left_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               sel_q, sel_d;
    logic               switch_q, switch_d;
    logic               done_q, done_d;

    logic rd_en;
    logic rd_last;
    logic last_frame;
    logic drain_exit;

    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        beat_d        = beat_q;
        frames_left_d = frames_left_q;
        drain_cnt_d   = drain_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        sel_d         = sel_q;
        switch_d      = switch_q;
        done_d        = 1'b0;
        rd_en         = 1'b0;
        rd_last       = 1'b0;
        last_frame    = (frames_left_q == FRAME_W'(1));
        drain_exit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    frame_cnt_d = '0;
                    if (i_frame_num == '0) begin
                        done_d = 1'b1;
                    end else begin
                        frames_left_d = i_frame_num;
                        state_d       = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                sel_d    = i_cfg_sel_16_32;
                switch_d = i_cfg_switch;
                beat_d   = '0;
                state_d  = ST_RUN;
            end

            ST_RUN: begin
                rd_en = i_ds_ready;
                if (rd_en) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        rd_last     = 1'b1;
                        beat_d      = '0;
                        drain_cnt_d = DRAIN_INIT;
                        state_d     = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (drain_cnt_q != '0) begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
                // Between frames the next LOAD overlaps the final drain cycle; on the
                // last frame we wait one more so the final y0_valid precedes o_done.
                drain_exit = last_frame ? (drain_cnt_q == '0)
                                        : (drain_cnt_q <= DRAIN_W'(1));
                if (drain_exit) begin
                    drain_cnt_d   = '0;
                    bank_d        = ~bank_q;
                    frames_left_d = frames_left_q - 1'b1;
                    if (frame_cnt_q != '1) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                    if (last_frame) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            bank_q        <= 1'b0;
            beat_q        <= '0;
            frames_left_q <= '0;
            drain_cnt_q   <= '0;
            frame_cnt_q   <= '0;
            sel_q         <= 1'b0;
            switch_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            beat_q        <= beat_d;
            frames_left_q <= frames_left_d;
            drain_cnt_q   <= drain_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            sel_q         <= sel_d;
            switch_q      <= switch_d;
            done_q        <= done_d;
        end
    end

    // RAM data lands one cycle after the strobe, so valid/last follow by the same amount.
    delay #(
        .WIDTH (2),
        .DEPTH (1)
    ) u_x0_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({rd_en, rd_last}),
        .q_o ({o_x0_valid, o_x0_last})
    );

    assign o_rd_en     = rd_en;
    assign o_rd_addr   = {bank_q, beat_q};
    assign o_sel_16_32 = sel_q;
    assign o_switch    = switch_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = done_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rsp_s1_prep_diff_ctrl.sv
// Directed bench for rsp_s1_prep_diff_ctrl with DATA_NUM=16, PIPE_LAT=4.
module tb_rsp_s1_prep_diff_ctrl;

    localparam int DN = 16;
    localparam int PL = 4;
    localparam int FW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [FW-1:0] i_frame_num;
    logic          i_cfg_sel_16_32;
    logic          i_cfg_switch;
    logic          i_ds_ready;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic          o_sel_16_32;
    logic          o_switch;
    logic          o_x0_valid;
    logic          o_x0_last;
    logic          o_busy;
    logic          o_done;
    logic [FW-1:0] o_frame_cnt;

    rsp_s1_prep_diff_ctrl #(
        .DATA_NUM (DN),
        .PIPE_LAT (PL),
        .FRAME_W  (FW),
        .ADDR_W   (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_frame_num     (i_frame_num),
        .i_cfg_sel_16_32 (i_cfg_sel_16_32),
        .i_cfg_switch    (i_cfg_switch),
        .i_ds_ready      (i_ds_ready),
        .o_rd_en         (o_rd_en),
        .o_rd_addr       (o_rd_addr),
        .o_sel_16_32     (o_sel_16_32),
        .o_switch        (o_switch),
        .o_x0_valid      (o_x0_valid),
        .o_x0_last       (o_x0_last),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_frame_cnt     (o_frame_cnt)
    );

    always #5 clk = ~clk;

    // {rd_en, addr[4:0], x0_valid, x0_last, busy, done, frame_cnt[15:0], sel, switch}
    logic [27:0] got;
    assign got = {o_rd_en, o_rd_addr, o_x0_valid, o_x0_last, o_busy, o_done,
                  o_frame_cnt, o_sel_16_32, o_switch};

    typedef struct {
        logic          start;
        logic [FW-1:0] fnum;
        logic          rdy;
        logic [27:0]   exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [27:0] pk(input logic rd, input logic [4:0] a, input logic xv,
                                       input logic xl, input logic busy, input logic done,
                                       input logic [15:0] fc, input logic s, input logic w);
        return {rd, a, xv, xl, busy, done, fc, s, w};
    endfunction

    task automatic add(input logic st, input logic [FW-1:0] fn, input logic rd,
                       input logic [27:0] e);
        vec_t v;
        v.start = st;
        v.fnum  = fn;
        v.rdy   = rd;
        v.exp   = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cyc[$];
        logic [AW-1:0] rd_adr[$];
        logic rd_sel[$];
        int done_cyc, addr_err, sel_err, sel_early, extra_rd, extra_busy;
        bit sent;
        int n_rd, n_xv, n_xl, last_idx, stall_a, stall_b, hold_err, xv_err;
        logic prev_rd;
        bit done_seen, reached;
        int first_rd;

        rst = 1'b1;
        i_start = 1'b0;
        i_frame_num = '0;
        i_cfg_sel_16_32 = 1'b0;
        i_cfg_switch = 1'b0;
        i_ds_ready = 1'b0;

        // Single frame, cycle by cycle from the start pulse (T) through done and beyond,
        // then a zero-frame start.
        add(1'b1, 16'd1, 1'b1, pk(0, 5'd0, 0, 0, 0, 0, 16'd0, 0, 0));
        add(1'b0, 16'd1, 1'b1, pk(0, 5'd0, 0, 0, 1, 0, 16'd0, 0, 0));
        for (int k = 0; k < DN; k++) begin
            add(1'b0, 16'd1, 1'b1, pk(1, 5'(k), k > 0, 0, 1, 0, 16'd0, 0, 0));
        end
        add(1'b0, 16'd1, 1'b1, pk(0, 5'd0, 1, 1, 1, 0, 16'd0, 0, 0));
        for (int k = 0; k < PL; k++) begin
            add(1'b0, 16'd1, 1'b1, pk(0, 5'd0, 0, 0, 1, 0, 16'd0, 0, 0));
        end
        add(1'b0, 16'd1, 1'b1, pk(0, 5'd16, 0, 0, 0, 1, 16'd1, 0, 0));
        add(1'b0, 16'd1, 1'b1, pk(0, 5'd16, 0, 0, 0, 0, 16'd1, 0, 0));
        add(1'b1, 16'd0, 1'b1, pk(0, 5'd16, 0, 0, 0, 0, 16'd1, 0, 0));
        add(1'b0, 16'd0, 1'b1, pk(0, 5'd16, 0, 0, 0, 1, 16'd0, 0, 0));
        add(1'b0, 16'd0, 1'b1, pk(0, 5'd16, 0, 0, 0, 0, 16'd0, 0, 0));

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", 64'(got), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            i_start     = tbl[i].start;
            i_frame_num = tbl[i].fnum;
            i_ds_ready  = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d", i), 64'(got), 64'(tbl[i].exp));
        end
        i_start = 1'b0;

        // Two frames, config toggled mid-frame 0, and a stray start during frame 1.
        pulse_reset();
        done_cyc = -1;
        sent = 1'b0;
        sel_early = 0;
        for (int c = 0; c < 150 && done_cyc < 0; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_frame_num = 16'd2;
            if (c == 0) begin
                i_start = 1'b1;
            end else if (rd_cyc.size() == 20 && !sent) begin
                i_start = 1'b1;
                i_frame_num = 16'd5;
                sent = 1'b1;
            end
            i_cfg_sel_16_32 = (rd_cyc.size() >= 5);
            i_ds_ready = 1'b1;
            #1;
            if (o_sel_16_32 && (rd_cyc.size() < 16 || (rd_cyc.size() == 16 && !o_rd_en))) begin
                sel_early++;
            end
            if (o_rd_en) begin
                rd_cyc.push_back(c);
                rd_adr.push_back(o_rd_addr);
                rd_sel.push_back(o_sel_16_32);
            end
            if (o_done) done_cyc = c;
        end
        i_start = 1'b0;
        chk("two_frame_reads", 64'(rd_cyc.size()), 64'd32);
        chk("two_frame_done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("two_frame_sel_early", 64'(sel_early), 64'd0);
        chk("two_frame_cnt", 64'(o_frame_cnt), 64'd2);
        if (rd_cyc.size() == 32) begin
            addr_err = 0;
            sel_err = 0;
            for (int k = 0; k < 32; k++) begin
                if (rd_adr[k] != AW'(k)) addr_err++;
                if (rd_sel[k] != (k >= 16)) sel_err++;
            end
            chk("two_frame_addr_err", 64'(addr_err), 64'd0);
            chk("two_frame_sel_err", 64'(sel_err), 64'd0);
            chk("start_to_first_read", 64'(rd_cyc[0]), 64'd2);
            chk("frame_gap", 64'(rd_cyc[16] - rd_cyc[15]), 64'(PL + 2));
            chk("last_read_to_done", 64'(done_cyc - rd_cyc[31]), 64'(PL + 2));
        end
        extra_rd = 0;
        extra_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (o_rd_en) extra_rd++;
            if (o_busy) extra_busy++;
        end
        chk("ignored_start_reads", 64'(extra_rd), 64'd0);
        chk("ignored_start_busy", 64'(extra_busy), 64'd0);

        // Backpressure: ready low for 3 cycles at beat 5 and at beat 15.
        n_rd = 0; n_xv = 0; n_xl = 0; last_idx = -1;
        stall_a = 0; stall_b = 0; hold_err = 0; xv_err = 0; addr_err = 0;
        prev_rd = 1'b0;
        done_seen = 1'b0;
        for (int c = 0; c < 150 && !done_seen; c++) begin
            @(negedge clk);
            i_start = (c == 0);
            i_frame_num = 16'd1;
            i_cfg_sel_16_32 = 1'b0;
            if (o_busy && n_rd == 5 && stall_a < 3) begin
                i_ds_ready = 1'b0;
                stall_a++;
            end else if (o_busy && n_rd == 15 && stall_b < 3) begin
                i_ds_ready = 1'b0;
                stall_b++;
            end else begin
                i_ds_ready = 1'b1;
            end
            #1;
            if (o_x0_valid !== prev_rd) xv_err++;
            if (!i_ds_ready && (o_rd_en || o_rd_addr != AW'(n_rd))) hold_err++;
            if (o_rd_en) begin
                if (o_rd_addr != AW'(n_rd)) addr_err++;
                n_rd++;
            end
            if (o_x0_valid) n_xv++;
            if (o_x0_last) begin
                n_xl++;
                last_idx = n_xv;
            end
            prev_rd = o_rd_en;
            if (o_done) done_seen = 1'b1;
        end
        i_start = 1'b0;
        i_ds_ready = 1'b1;
        chk("bp_done_seen", 64'(done_seen), 64'd1);
        chk("bp_stalls", 64'({stall_a[7:0], stall_b[7:0]}), 64'h0303);
        chk("bp_reads", 64'(n_rd), 64'(DN));
        chk("bp_valids", 64'(n_xv), 64'(DN));
        chk("bp_last_count", 64'(n_xl), 64'd1);
        chk("bp_last_on_final_valid", 64'(last_idx), 64'(DN));
        chk("bp_addr_err", 64'(addr_err), 64'd0);
        chk("bp_hold_err", 64'(hold_err), 64'd0);
        chk("bp_valid_delay_err", 64'(xv_err), 64'd0);

        // Reset mid-RUN at beat 7 of a bank-1 frame, then restart from bank 0.
        reached = 1'b0;
        i_cfg_sel_16_32 = 1'b1;
        i_cfg_switch = 1'b1;
        for (int c = 0; c < 60 && !reached; c++) begin
            @(negedge clk);
            i_start = (c == 0);
            i_frame_num = 16'd3;
            #1;
            if (o_rd_en && o_rd_addr == 5'd23) reached = 1'b1;
        end
        i_start = 1'b0;
        chk("rst_reach_beat7_bank1", 64'(reached), 64'd1);
        chk("pre_rst_mode", 64'({o_sel_16_32, o_switch}), 64'd3);
        rst = 1'b1;
        #1;
        chk("rst_mid_run_outputs", 64'(got), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        i_cfg_sel_16_32 = 1'b0;
        i_cfg_switch = 1'b0;
        first_rd = -1;
        for (int c = 0; c < 10 && first_rd < 0; c++) begin
            @(negedge clk);
            i_start = (c == 0);
            i_frame_num = 16'd1;
            #1;
            if (o_rd_en) begin
                first_rd = c;
                chk("post_rst_first_addr", 64'(o_rd_addr), 64'd0);
            end
        end
        i_start = 1'b0;
        chk("post_rst_first_read_cycle", 64'(first_rd), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
